// File: rtl/move_sequencer_pkg.sv
// move_sequencer_pkg: shared definitions for the Connect-4 move sequencer.
//   - game_status_t : game status encodings driven on game_status
//   - S_*           : FSM state encodings
//   - LINE_CELLS    : cell indices of the 10 winning lines on the 4x4 board
//                     (cell = row*4 + col, row 0 at the bottom)
//   - NO_WIN        : win_line value when no line has been found
package move_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_PLAYING = 2'b00,
    ST_P1_WIN  = 2'b01,
    ST_P2_WIN  = 2'b10,
    ST_DRAW    = 2'b11
  } game_status_t;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_SCAN    = 3'd4;
  localparam logic [2:0] S_RESOLVE = 3'd5;
  localparam logic [2:0] S_OVER    = 3'd6;

  localparam int NUM_LINES = 10;
  localparam logic [3:0] NO_WIN = 4'hF;

  // Lines 0-3: rows, 4-7: columns, 8: diagonal, 9: anti-diagonal.
  localparam logic [3:0] LINE_CELLS [NUM_LINES][4] = '{
    '{4'd0,  4'd1,  4'd2,  4'd3 },
    '{4'd4,  4'd5,  4'd6,  4'd7 },
    '{4'd8,  4'd9,  4'd10, 4'd11},
    '{4'd12, 4'd13, 4'd14, 4'd15},
    '{4'd0,  4'd4,  4'd8,  4'd12},
    '{4'd1,  4'd5,  4'd9,  4'd13},
    '{4'd2,  4'd6,  4'd10, 4'd14},
    '{4'd3,  4'd7,  4'd11, 4'd15},
    '{4'd0,  4'd5,  4'd10, 4'd15},
    '{4'd3,  4'd6,  4'd9,  4'd12}
  };

endpackage

// File: rtl/move_sequencer_if.sv
// move_sequencer_if: move request handshake between the player input logic
// (master) and the move sequencer (slave).
//   move_valid  : move request valid (master -> slave)
//   move_column : requested column 0-3 (master -> slave)
//   move_ready  : sequencer can accept a move (slave -> master)
//   move_reject : one-cycle pulse, move refused (slave -> master)
//   move_done   : one-cycle pulse, move fully resolved (slave -> master)
interface move_sequencer_if;
  logic       move_valid;
  logic [1:0] move_column;
  logic       move_ready;
  logic       move_reject;
  logic       move_done;

  modport master (
    output move_valid, move_column,
    input  move_ready, move_reject, move_done
  );

  modport slave (
    input  move_valid, move_column,
    output move_ready, move_reject, move_done
  );
endinterface

// File: rtl/move_sequencer_line_checker.sv
// move_sequencer_line_checker: combinational test of one winning line.
//   line          : line index 0-9 (other values never hit)
//   gameboard     : cell occupancy, 1 = occupied
//   players_cells : cell owner, 0 = P1, 1 = P2
//   player        : player whose win is being tested
//   hit           : all four cells of the line occupied and owned by player
module move_sequencer_line_checker
  import move_sequencer_pkg::*;
(
  input  logic [3:0]  line,
  input  logic [15:0] gameboard,
  input  logic [15:0] players_cells,
  input  logic        player,
  output logic        hit
);

  logic [NUM_LINES-1:0] hit_vec;

  // Every line is evaluated in parallel from constant cell indices; the
  // line index then only drives a 10:1 bit select.
  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
    logic [3:0] occ;
    logic [3:0] own;
    for (genvar gk = 0; gk < 4; gk++) begin : g_cell
      assign occ[gk] = gameboard[LINE_CELLS[gi][gk]];
      assign own[gk] = players_cells[LINE_CELLS[gi][gk]];
    end
    assign hit_vec[gi] = (&occ) && (own == {4{player}});
  end

  assign hit = (line < 4'(NUM_LINES)) ? hit_vec[line] : 1'b0;

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: sequences one Connect-4 move on the 4x4 board.
//   clk           : system clock, rising edge
//   reset         : asynchronous active-low reset
//   mv            : move request handshake (slave side)
//   new_game      : game clear request, honoured in IDLE and OVER
//   gameboard     : occupancy from the selector
//   players_cells : cell ownership from the selector
//   sel_enable    : one-cycle enable to the column calculator/selector
//   sel_column    : requested column, zero-extended, stable ISSUE..WAIT
//   board_clear   : one-cycle pulse clearing the selector board
//   player_turn   : player to move, 0 = P1, 1 = P2
//   game_status   : 00 playing, 01 P1 won, 10 P2 won, 11 draw
//   busy          : high in every state except IDLE and OVER
//   win_line      : index of the winning line, 4'hF when none
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  move_sequencer_if.slave      mv,
  input  logic                 new_game,
  input  logic [15:0]          gameboard,
  input  logic [15:0]          players_cells,
  output logic                 sel_enable,
  output logic [3:0]           sel_column,
  output logic                 board_clear,
  output logic                 player_turn,
  output logic [1:0]           game_status,
  output logic                 busy,
  output logic [3:0]           win_line
);

  logic [2:0]   state_reg;
  logic [1:0]   col_reg;
  logic [3:0]   cnt_reg;
  logic [3:0]   win_line_reg;
  logic         turn_reg;
  game_status_t status_reg;
  logic         board_clear_reg;
  logic         over_reject_reg;
  logic         line_hit;

  // The scan counter doubles as the line index, so one checker covers all lines.
  move_sequencer_line_checker u_line_checker (
    .line          (cnt_reg),
    .gameboard     (gameboard),
    .players_cells (players_cells),
    .player        (turn_reg),
    .hit           (line_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      col_reg         <= 2'd0;
      cnt_reg         <= 4'd0;
      win_line_reg    <= NO_WIN;
      turn_reg        <= 1'b0;
      status_reg      <= ST_PLAYING;
      board_clear_reg <= 1'b0;
      over_reject_reg <= 1'b0;
    end else begin
      board_clear_reg <= 1'b0;
      over_reject_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // new_game has priority over a simultaneous move request.
          if (new_game) begin
            board_clear_reg <= 1'b1;
            status_reg      <= ST_PLAYING;
            turn_reg        <= 1'b0;
            win_line_reg    <= NO_WIN;
          end else if (mv.move_valid) begin
            col_reg      <= mv.move_column;
            win_line_reg <= NO_WIN;
            state_reg    <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Top-row cell of the column is 12 + col.
          if (gameboard[{2'b11, col_reg}]) state_reg <= S_IDLE;
          else                             state_reg <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt_reg   <= 4'd0;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_reg == 4'(SETTLE_CYCLES - 1)) begin
            cnt_reg   <= 4'd0;
            state_reg <= S_SCAN;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        S_SCAN: begin
          // Keep only the first hit; the scan always runs all lines.
          if (line_hit && (win_line_reg == NO_WIN)) win_line_reg <= cnt_reg;
          if (cnt_reg == 4'(NUM_LINES - 1)) begin
            cnt_reg   <= 4'd0;
            state_reg <= S_RESOLVE;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        S_RESOLVE: begin
          if (win_line_reg != NO_WIN) begin
            status_reg <= turn_reg ? ST_P2_WIN : ST_P1_WIN;
            state_reg  <= S_OVER;
          end else if (&gameboard) begin
            status_reg <= ST_DRAW;
            state_reg  <= S_OVER;
          end else begin
            turn_reg  <= ~turn_reg;
            state_reg <= S_IDLE;
          end
        end
        S_OVER: begin
          if (new_game) begin
            board_clear_reg <= 1'b1;
            status_reg      <= ST_PLAYING;
            turn_reg        <= 1'b0;
            win_line_reg    <= NO_WIN;
            state_reg       <= S_IDLE;
          end else if (mv.move_valid) begin
            over_reject_reg <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign mv.move_ready  = (state_reg == S_IDLE);
  assign mv.move_reject = ((state_reg == S_CHECK) && gameboard[{2'b11, col_reg}])
                          || over_reject_reg;
  assign mv.move_done   = (state_reg == S_RESOLVE);
  assign sel_enable     = (state_reg == S_ISSUE);
  assign sel_column     = {2'b00, col_reg};
  assign board_clear    = board_clear_reg;
  assign player_turn    = turn_reg;
  assign game_status    = status_reg;
  assign busy           = (state_reg != S_IDLE) && (state_reg != S_OVER);
  assign win_line       = win_line_reg;

endmodule
